// File: rtl/cubic_interp_pipe.sv
// Four-stage Catmull-Rom cubic interpolator with per-channel Horner evaluation,
// output clamp and valid/ready flow control with full backpressure.
module cubic_interp_pipe #(
  parameter int BIT_DEPTH = 8,
  parameter int FRAC_BITS = 6,
  parameter int CHANNELS  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*BIT_DEPTH-1:0] in_a0,
  input  logic [CHANNELS*BIT_DEPTH-1:0] in_a1,
  input  logic [CHANNELS*BIT_DEPTH-1:0] in_a2,
  input  logic [CHANNELS*BIT_DEPTH-1:0] in_a3,
  input  logic [FRAC_BITS-1:0]          in_frac,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*BIT_DEPTH-1:0] out_pix,
  output logic                          out_last
);

  localparam int CW = BIT_DEPTH + 4;
  localparam int AW = BIT_DEPTH + 6;
  localparam int PW = BIT_DEPTH + FRAC_BITS + 7;
  localparam int PX = CHANNELS * BIT_DEPTH;

  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t MAXV = acc_t'((1 << BIT_DEPTH) - 1);

  // s * frac / 2^FRAC_BITS, floored toward -inf
  function automatic acc_t fmul(acc_t s, logic [FRAC_BITS-1:0] f);
    logic signed [PW-1:0] p;
    p = PW'(s) * $signed(PW'(f));
    return AW'(p >>> FRAC_BITS);
  endfunction

  function automatic coef_t tap(logic [PX-1:0] v, int c);
    return coef_t'({4'b0, v[c*BIT_DEPTH +: BIT_DEPTH]});
  endfunction

  logic adv;

  logic v0_q, v1_q, v2_q, v3_q;
  logic l0_q, l1_q, l2_q, l3_q;
  logic [FRAC_BITS-1:0] f0_q, f1_q, f2_q;

  coef_t t0_d [CHANNELS];
  coef_t t1_d [CHANNELS];
  coef_t t2_d [CHANNELS];
  coef_t t3_d [CHANNELS];
  coef_t t0_0_q [CHANNELS];
  coef_t t1_0_q [CHANNELS];
  coef_t t2_0_q [CHANNELS];
  coef_t t3_0_q [CHANNELS];

  acc_t  s2_d [CHANNELS];
  coef_t t0_1_q [CHANNELS];
  coef_t t1_1_q [CHANNELS];
  acc_t  s2_1_q [CHANNELS];

  acc_t  s1_d [CHANNELS];
  coef_t t0_2_q [CHANNELS];
  acc_t  s1_2_q [CHANNELS];

  logic [PX-1:0] pix_d;
  logic [PX-1:0] pix_q;

  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_last  = l3_q;
  assign out_pix   = pix_q;

  always_comb begin
    coef_t a0, a1, a2, a3;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      a0 = tap(in_a0, c);
      a1 = tap(in_a1, c);
      a2 = tap(in_a2, c);
      a3 = tap(in_a3, c);
      t0_d[c] = a1;
      t1_d[c] = (a2 >>> 1) - (a0 >>> 1);
      t2_d[c] = a0 - ((a1 <<< 1) + (a1 >>> 1))
              + (a2 <<< 1) - (a3 >>> 1);
      t3_d[c] = (a1 + (a1 >>> 1)) - (a0 >>> 1)
              + (a3 >>> 1) - (a2 + (a2 >>> 1));
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      s2_d[c] = fmul(AW'(t3_0_q[c]), f0_q) + AW'(t2_0_q[c]);
      s1_d[c] = fmul(s2_1_q[c], f1_q) + AW'(t1_1_q[c]);
    end
  end

  always_comb begin
    acc_t y;
    y     = '0;
    pix_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      y = fmul(s1_2_q[c], f2_q) + AW'(t0_2_q[c]);
      if (y[AW-1])
        pix_d[c*BIT_DEPTH +: BIT_DEPTH] = '0;
      else if (y > MAXV)
        pix_d[c*BIT_DEPTH +: BIT_DEPTH] = '1;
      else
        pix_d[c*BIT_DEPTH +: BIT_DEPTH] = y[BIT_DEPTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      l3_q  <= 1'b0;
      pix_q <= '0;
    end else if (adv) begin
      v0_q  <= in_valid;
      v1_q  <= v0_q;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      l3_q  <= l2_q;
      pix_q <= pix_d;
    end
  end

  // Payload only matters alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      l0_q <= in_last;
      l1_q <= l0_q;
      l2_q <= l1_q;
      f0_q <= in_frac;
      f1_q <= f0_q;
      f2_q <= f1_q;
      for (int c = 0; c < CHANNELS; c++) begin
        t0_0_q[c] <= t0_d[c];
        t1_0_q[c] <= t1_d[c];
        t2_0_q[c] <= t2_d[c];
        t3_0_q[c] <= t3_d[c];
        t0_1_q[c] <= t0_0_q[c];
        t1_1_q[c] <= t1_0_q[c];
        s2_1_q[c] <= s2_d[c];
        t0_2_q[c] <= t0_1_q[c];
        s1_2_q[c] <= s1_d[c];
      end
    end
  end

endmodule

// File: tb/tb_cubic_interp_pipe.sv
// Bench for cubic_interp_pipe: directed taps, phase sweep, backpressure,
// reset flush and randomized traffic against an integer reference model.
module tb_cubic_interp_pipe;

  localparam int BD = 8;
  localparam int FB = 6;
  localparam int CH = 3;
  localparam int W  = BD * CH;

  typedef struct {
    logic [W-1:0]  a0;
    logic [W-1:0]  a1;
    logic [W-1:0]  a2;
    logic [W-1:0]  a3;
    logic [FB-1:0] f;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a0 = '0;
  logic [W-1:0]  in_a1 = '0;
  logic [W-1:0]  in_a2 = '0;
  logic [W-1:0]  in_a3 = '0;
  logic [FB-1:0] in_frac = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_pix;
  logic          out_last;

  int checks = 0;
  int failures = 0;

  cubic_interp_pipe #(
    .BIT_DEPTH(BD),
    .FRAC_BITS(FB),
    .CHANNELS (CH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a0    (in_a0),
    .in_a1    (in_a1),
    .in_a2    (in_a2),
    .in_a3    (in_a3),
    .in_frac  (in_frac),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pix  (out_pix),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  // floor(v / 2^FB)
  function automatic int fdiv(int v);
    int d;
    d = 1 << FB;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic logic [W-1:0] model(beat_t b);
    logic [W-1:0] r;
    int p0, p1, p2, p3, c1, c2, c3, x, y;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      p0 = int'(b.a0[c*BD +: BD]);
      p1 = int'(b.a1[c*BD +: BD]);
      p2 = int'(b.a2[c*BD +: BD]);
      p3 = int'(b.a3[c*BD +: BD]);
      c1 = p2 / 2 - p0 / 2;
      c2 = p0 - 2 * p1 - p1 / 2 + 2 * p2 - p3 / 2;
      c3 = p1 + p1 / 2 - p0 / 2 + p3 / 2 - p2 - p2 / 2;
      x  = int'(b.f);
      y  = fdiv(c3 * x) + c2;
      y  = fdiv(y * x) + c1;
      y  = fdiv(y * x) + p1;
      if (y < 0) y = 0;
      if (y > (1 << BD) - 1) y = (1 << BD) - 1;
      r[c*BD +: BD] = y[BD-1:0];
    end
    return r;
  endfunction

  function automatic beat_t mk(int x0, int x1, int x2, int x3,
                               int f, logic last);
    beat_t b;
    b.a0   = {CH{BD'(x0)}};
    b.a1   = {CH{BD'(x1)}};
    b.a2   = {CH{BD'(x2)}};
    b.a3   = {CH{BD'(x3)}};
    b.f    = FB'(f);
    b.last = last;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.a0   = W'($urandom);
    b.a1   = W'($urandom);
    b.a2   = W'($urandom);
    b.a3   = W'($urandom);
    b.f    = FB'($urandom);
    b.last = 1'($urandom);
    return b;
  endfunction

  task automatic drive(beat_t b, logic v);
    in_valid = v;
    in_a0    = b.a0;
    in_a1    = b.a1;
    in_a2    = b.a2;
    in_a3    = b.a3;
    in_frac  = b.f;
    in_last  = b.last;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_pix !== '0) begin
      failures++;
      $display("FAIL reset_pix got=%h want=0", out_pix);
    end
    checks++;
    if (out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_last got=%b want=0", out_last);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_directed();
    beat_t        bt [5];
    logic [W-1:0] want [5];
    int           n;
    bt[0] = mk(10, 20, 30, 40, 0, 1'b0);
    want[0] = {CH{8'd20}};
    bt[1] = mk(10, 20, 30, 40, 32, 1'b1);
    want[1] = {CH{8'd25}};
    bt[2] = mk(0, 255, 255, 0, 32, 1'b0);
    want[2] = {CH{8'd255}};
    bt[3] = mk(255, 0, 0, 255, 32, 1'b1);
    want[3] = {CH{8'd0}};
    bt[4].a0 = {8'd255, 8'd0,   8'd10};
    bt[4].a1 = {8'd0,   8'd255, 8'd20};
    bt[4].a2 = {8'd0,   8'd255, 8'd30};
    bt[4].a3 = {8'd255, 8'd0,   8'd40};
    bt[4].f = 6'd32;
    bt[4].last = 1'b1;
    want[4] = {8'd0, 8'd255, 8'd25};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(bt[i], 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 4) begin
        failures++;
        $display("FAIL dir%0d_latency got=%0d want=4", i, n);
      end
      checks++;
      if (out_pix !== want[i]) begin
        failures++;
        $display("FAIL dir%0d_pix got=%h want=%h", i, out_pix, want[i]);
      end
      checks++;
      if (out_pix !== model(bt[i])) begin
        failures++;
        $display("FAIL dir%0d_model got=%h want=%h", i, out_pix,
                 model(bt[i]));
      end
      checks++;
      if (out_last !== bt[i].last) begin
        failures++;
        $display("FAIL dir%0d_last got=%b want=%b", i, out_last,
                 bt[i].last);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_single got=%b want=0", i, out_valid);
      end
    end
  endtask

  task automatic test_const_sweep();
    int sent, got, cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (got < 64 && cyc < 200) begin
      if (sent < 64) drive(mk(100, 100, 100, 100, sent, sent == 63), 1'b1);
      else in_valid = 1'b0;
      #1;
      if (got > 0 && got < 64) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL sweep_gap beat=%0d got=%b want=1", got, out_valid);
        end
      end
      if (out_valid) begin
        checks++;
        if (out_pix !== {CH{8'd100}}) begin
          failures++;
          $display("FAIL sweep_pix frac=%0d got=%h want=646464", got, out_pix);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 64 || cyc !== 68) begin
      failures++;
      $display("FAIL sweep_count got=%0d/%0d cycles want=64/68", got, cyc);
    end
  endtask

  task automatic test_backpressure();
    beat_t        bs [8];
    beat_t        acc [$];
    beat_t        e;
    logic [W-1:0] held;
    logic         hl, hv;
    int           sent, got, cyc;
    for (int i = 0; i < 8; i++) begin
      bs[i] = rand_beat();
      bs[i].last = (i == 7);
    end
    sent = 0;
    got = 0;
    cyc = 0;
    hv = 1'b0;
    held = '0;
    hl = 1'b0;
    while (got < 8 && cyc < 100) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      if (sent < 8) drive(bs[sent], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
        end
      end
      if (hv) begin
        checks++;
        if (out_valid !== 1'b1 || out_pix !== held || out_last !== hl) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/%h",
                   cyc, out_valid, out_pix, held);
        end
      end
      if (out_valid && out_ready) begin
        e = acc.pop_front();
        checks++;
        if (out_pix !== model(e) || out_last !== e.last) begin
          failures++;
          $display("FAIL bp_data beat=%0d got=%h/%b want=%h/%b",
                   got, out_pix, out_last, model(e), e.last);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        acc.push_back(bs[sent]);
        sent++;
      end
      hv = out_valid && !out_ready;
      held = out_pix;
      hl = out_last;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 8) begin
      failures++;
      $display("FAIL bp_count got=%0d want=8", got);
    end
  endtask

  task automatic test_reset_midstream();
    beat_t b;
    int    n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = rand_beat();
      b.last = 1'b1;
      drive(b, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_pix !== '0) begin
      failures++;
      $display("FAIL rst_flush got=%b/%b/%h want=0/0/0",
               out_valid, out_last, out_pix);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_stale cyc=%0d got=%b want=0", k, out_valid);
      end
      tick();
    end
    b = rand_beat();
    drive(b, 1'b1);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL rst_latency got=%0d want=4", n);
    end
    checks++;
    if (out_pix !== model(b) || out_last !== b.last) begin
      failures++;
      $display("FAIL rst_first got=%h/%b want=%h/%b",
               out_pix, out_last, model(b), b.last);
    end
    tick();
  endtask

  task automatic test_random();
    beat_t        acc [$];
    beat_t        b, e;
    logic [W-1:0] held;
    logic         hl, hv;
    int           sent, got;
    sent = 0;
    got = 0;
    hv = 1'b0;
    held = '0;
    hl = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      b = rand_beat();
      out_ready = (cyc >= 360) || ($urandom_range(0, 3) != 0);
      drive(b, (cyc < 360) && ($urandom_range(0, 3) != 0));
      #1;
      if (hv) begin
        checks++;
        if (out_valid !== 1'b1 || out_pix !== held || out_last !== hl) begin
          failures++;
          $display("FAIL rnd_hold cyc=%0d got=%b/%h want=1/%h",
                   cyc, out_valid, out_pix, held);
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b",
                 cyc, in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (acc.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra cyc=%0d got=%h want=none", cyc, out_pix);
        end else begin
          e = acc.pop_front();
          if (out_pix !== model(e) || out_last !== e.last) begin
            failures++;
            $display("FAIL rnd_data beat=%0d got=%h/%b want=%h/%b",
                     got, out_pix, out_last, model(e), e.last);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        acc.push_back(b);
        sent++;
      end
      hv = out_valid && !out_ready;
      held = out_pix;
      hl = out_last;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got !== sent || acc.size() !== 0) begin
      failures++;
      $display("FAIL rnd_count got=%0d want=%0d", got, sent);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_const_sweep();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
